// File: rtl/hello_world_demo_led_pkg.sv
// Shared constants for the hello_world_demo_led output PIO: register map and
// default blink prescale. Blink engine is enabled by HELLO_WORLD_DEMO_LED_BLINK_EN.
package hello_world_demo_led_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_OUTSET   = 2'd1;
  localparam logic [1:0] ADDR_OUTCLEAR = 2'd2;
  localparam logic [1:0] ADDR_BLINK    = 2'd3;

  localparam int DEFAULT_BLINK_DIV = 25000000;

endpackage

// File: rtl/hello_world_demo_led_blink_timer.sv
// Free-running blink prescaler: toggles phase every BLINK_DIV cycles.
// Compiled only when HELLO_WORLD_DEMO_LED_BLINK_EN is defined.
`ifdef HELLO_WORLD_DEMO_LED_BLINK_EN
module hello_world_demo_led_blink_timer
  import hello_world_demo_led_pkg::*;
#(
  parameter int BLINK_DIV = DEFAULT_BLINK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic phase
);

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] TERM = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          term_cnt;

  assign term_cnt = (cnt_q == TERM);

  // A restart overrides a coincident terminal count: both counter and phase go to 0.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (term_cnt) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule
`endif

// File: rtl/hello_world_demo_led.sv
// Avalon-MM output PIO driving board LEDs with set/clear aliases and an
// optional blink engine enabled by HELLO_WORLD_DEMO_LED_BLINK_EN.
module hello_world_demo_led
  import hello_world_demo_led_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BLINK_DIV = DEFAULT_BLINK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  // Bus semantics: a write is chipselect && !write_n, sampled on the rising
  // edge; reads have no strobe and readdata is reloaded from address every cycle.
  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [31:0]      rd_q, rd_d;

  assign wr_en = chipselect && !write_n;
  assign wd    = writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_unused_wd
      logic unused_wd_hi;
      assign unused_wd_hi = |writedata[31:WIDTH];
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_d = wd;
        ADDR_OUTSET:   data_d = data_q | wd;
        ADDR_OUTCLEAR: data_d = data_q & ~wd;
        default:       data_d = data_q;
      endcase
    end
  end

`ifdef HELLO_WORLD_DEMO_LED_BLINK_EN
  logic [WIDTH-1:0] blink_mask_q, blink_mask_d;
  logic             blink_restart;
  logic             phase;

  assign blink_restart = wr_en && (address == ADDR_BLINK);

  always_comb begin
    blink_mask_d = blink_mask_q;
    if (blink_restart) blink_mask_d = wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blink_mask_q <= '0;
    else       blink_mask_q <= blink_mask_d;
  end

  hello_world_demo_led_blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (blink_restart),
    .phase   (phase)
  );

  assign out_d = data_q ^ (blink_mask_q & {WIDTH{phase}});
`else
  localparam int unused_blink_div = BLINK_DIV;
  assign out_d = data_q;
`endif

  // Read mux uses register contents before the edge, so a same-cycle write reads old data.
  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA:   rd_d[WIDTH-1:0] = data_q;
      ADDR_OUTSET: rd_d[WIDTH-1:0] = out_q;
`ifdef HELLO_WORLD_DEMO_LED_BLINK_EN
      ADDR_BLINK:  rd_d[WIDTH-1:0] = blink_mask_q;
`endif
      default:     rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      out_q  <= '0;
      rd_q   <= '0;
    end else begin
      data_q <= data_d;
      out_q  <= out_d;
      rd_q   <= rd_d;
    end
  end

  assign out_port = out_q;
  assign readdata = rd_q;

endmodule

// File: tb/tb_hello_world_demo_led.sv
// Directed self-checking bench for hello_world_demo_led (WIDTH=8, BLINK_DIV=4).
// Blink scenarios run when HELLO_WORLD_DEMO_LED_BLINK_EN is defined.
module tb_hello_world_demo_led;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int errors;
  int checks;

  hello_world_demo_led #(
    .WIDTH     (8),
    .BLINK_DIV (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: every tick returns 1ns after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    #2;
    checks++;
    if (out_port !== 8'h00) begin
      errors++; $display("FAIL reset_out got=%h exp=00", out_port);
    end
    checks++;
    if (readdata !== 32'h0) begin
      errors++; $display("FAIL reset_rd got=%h exp=00000000", readdata);
    end
    tick();
    reset = 1'b0;
    tick();
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++; $display("FAIL idle_rd addr=%0d got=%h exp=00000000", a, rd);
      end
    end
    checks++;
    if (out_port !== 8'h00) begin
      errors++; $display("FAIL idle_out got=%h exp=00", out_port);
    end
  endtask

  task automatic test_data_write();
    logic [31:0] rd;
    bus_write(2'd0, 32'h0000_01A5);
    checks++;
    if (out_port !== 8'h00) begin
      errors++; $display("FAIL data_latency got=%h exp=00", out_port);
    end
    tick();
    checks++;
    if (out_port !== 8'hA5) begin
      errors++; $display("FAIL data_out got=%h exp=a5", out_port);
    end
    bus_read(2'd0, rd);
    checks++;
    if (rd !== 32'h0000_00A5) begin
      errors++; $display("FAIL data_rd got=%h exp=000000a5", rd);
    end
    bus_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0000_00A5) begin
      errors++; $display("FAIL outset_rd_a got=%h exp=000000a5", rd);
    end
  endtask

  task automatic test_set_clear();
    logic [31:0] rd;
    bus_write(2'd1, 32'h0000_000F);
    tick();
    checks++;
    if (out_port !== 8'hAF) begin
      errors++; $display("FAIL outset_out got=%h exp=af", out_port);
    end
    bus_write(2'd2, 32'h0000_0081);
    tick();
    checks++;
    if (out_port !== 8'h2E) begin
      errors++; $display("FAIL outclear_out got=%h exp=2e", out_port);
    end
    bus_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0000_002E) begin
      errors++; $display("FAIL outset_rd_b got=%h exp=0000002e", rd);
    end
    bus_read(2'd2, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL outclear_rd got=%h exp=00000000", rd);
    end
    bus_read(2'd0, rd);
    checks++;
    if (rd !== 32'h0000_002E) begin
      errors++; $display("FAIL data_rd_b got=%h exp=0000002e", rd);
    end
  endtask

  task automatic test_read_during_write();
    bus_write(2'd0, 32'h0000_0055);
    checks++;
    if (readdata !== 32'h0000_002E) begin
      errors++; $display("FAIL rdw_old got=%h exp=0000002e", readdata);
    end
    tick();
    checks++;
    if (readdata !== 32'h0000_0055) begin
      errors++; $display("FAIL rdw_new got=%h exp=00000055", readdata);
    end
    checks++;
    if (out_port !== 8'h55) begin
      errors++; $display("FAIL rdw_out got=%h exp=55", out_port);
    end
  endtask

`ifdef HELLO_WORLD_DEMO_LED_BLINK_EN
  task automatic test_blink();
    logic [31:0] rd;
    logic [7:0]  exp;
    bus_write(2'd0, 32'h0);
    bus_write(2'd3, 32'h03);
    // after edge k+i, out reflects phase after edge k+i-1
    for (int i = 1; i <= 13; i++) begin
      tick();
      exp = ((((i - 1) / 4) % 2) != 0) ? 8'h03 : 8'h00;
      checks++;
      if (out_port !== exp) begin
        errors++; $display("FAIL blink_seq edge=k+%0d got=%h exp=%h", i, out_port, exp);
      end
    end
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h03) begin
      errors++; $display("FAIL blink_rd got=%h exp=00000003", rd);
    end
  endtask

  task automatic test_blink_restart_on_tc();
    bus_write(2'd3, 32'h03);
    tick(); tick(); tick();
    bus_write(2'd3, 32'h03);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (out_port !== ((i == 5) ? 8'h03 : 8'h00)) begin
        errors++; $display("FAIL blink_tc edge=k+%0d got=%h exp=%h", i, out_port,
                           (i == 5) ? 8'h03 : 8'h00);
      end
    end
  endtask

  task automatic test_reset_mid_blink();
    logic [31:0] rd;
    checks++;
    if (out_port !== 8'h03) begin
      errors++; $display("FAIL mid_pre got=%h exp=03", out_port);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_port !== 8'h00) begin
      errors++; $display("FAIL mid_reset_out got=%h exp=00", out_port);
    end
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (out_port !== 8'h00) begin
        errors++; $display("FAIL post_reset_out edge=%0d got=%h exp=00", i, out_port);
      end
    end
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL post_reset_mask got=%h exp=00000000", rd);
    end
    bus_write(2'd3, 32'h03);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (out_port !== ((i == 5) ? 8'h03 : 8'h00)) begin
        errors++; $display("FAIL post_reset_blink edge=k+%0d got=%h exp=%h", i, out_port,
                           (i == 5) ? 8'h03 : 8'h00);
      end
    end
  endtask
`else
  task automatic test_no_blink();
    logic [31:0] rd;
    bus_write(2'd3, 32'hFF);
    tick(); tick();
    checks++;
    if (out_port !== 8'h55) begin
      errors++; $display("FAIL noblink_out got=%h exp=55", out_port);
    end
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL noblink_rd got=%h exp=00000000", rd);
    end
    bus_read(2'd0, rd);
    checks++;
    if (rd !== 32'h55) begin
      errors++; $display("FAIL noblink_data got=%h exp=00000055", rd);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (out_port !== 8'h55) begin
        errors++; $display("FAIL noblink_hold cyc=%0d got=%h exp=55", i, out_port);
      end
    end
  endtask
`endif

  initial begin
    errors     = 0;
    checks     = 0;
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    test_reset();
    test_data_write();
    test_set_clear();
    test_read_during_write();
`ifdef HELLO_WORLD_DEMO_LED_BLINK_EN
    test_blink();
    test_blink_restart_on_tc();
    test_reset_mid_blink();
`else
    test_no_blink();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hello_world_demo_led.md
# hello_world_demo_led

Avalon-MM slave output PIO: the write-side counterpart to the key input port. It drives a WIDTH-bit `out_port` (board LEDs) from a Nios-writable data register, with atomic set/clear aliases and an optional hardware blink engine that toggles masked bits at a fixed prescaled rate without CPU involvement. It sits on the system interconnect beside the key PIO and uses the same read path: a fixed address decode and a registered `readdata`.

## Interface
- `WIDTH`, 8, number of output bits (1..32)
- `BLINK_DIV`, 25000000, clock cycles per blink half-period (>= 2); used only with blink compiled in

- `clk` in 1: single system clock, all logic rising-edge
- `reset` in 1: asynchronous, active-high reset
- `address` in 2: register select
- `chipselect` in 1: slave select, qualifies writes
- `write_n` in 1: active-low write strobe; a write occurs when `chipselect && !write_n`
- `writedata` in 32: write data; bits above WIDTH ignored
- `readdata` out 32: registered read data, zero-extended above WIDTH
- `out_port` out WIDTH: registered LED drive

## Operation
- Registers:
  - address 0, DATA: a write loads `data_reg`. A read returns `data_reg`.
  - address 1, OUTSET: a write applies `data_reg |= writedata`. A read returns the current `out_port`.
  - address 2, OUTCLEAR: a write applies `data_reg &= ~writedata`. A read returns 0.
  - address 3, BLINK: a write loads `blink_mask`, clears the prescaler and clears `phase` to 0. A read returns `blink_mask`.
- Blink engine:
  - The prescaler counts 0..BLINK_DIV-1 every cycle.
  - At terminal count it wraps to 0 and toggles `phase`.
  - A BLINK write in the same cycle as terminal count takes priority: counter and `phase` both become 0.
- Output: `out_port <= data_reg ^ (blink_mask & {WIDTH{phase}})`, registered.
- Only one register is written per cycle. Writes to different addresses never conflict.
- Reads have no strobe. `readdata` is updated every cycle from `address`, whether or not `chipselect` is asserted.
- Reset values: `data_reg`=0, `blink_mask`=0, prescaler=0, `phase`=0, `out_port`=0, `readdata`=0.
- Reset asserted mid-blink returns all state to the reset values immediately. The prescaler restarts from 0 after reset releases.

## Timing
- A write sampled at edge k commits its register at edge k. The effect appears on `out_port` after edge k+1, giving 1 cycle of output latency.
- Read latency is 1: `readdata` after edge k reflects `address` at edge k and register contents before edge k.
- A read and a write to the same address at edge k return the old value. The new value is visible from edge k+1.
- With blink enabled and a nonzero mask, masked bits toggle every BLINK_DIV cycles. Full period is 2*BLINK_DIV.
- After a BLINK write at edge k, the first toggle of `phase` occurs at edge k+BLINK_DIV. `out_port` follows one edge later.
- Prescaler width is `$clog2(BLINK_DIV)`. There is no overflow beyond BLINK_DIV-1.

## Configuration
- `HELLO_WORLD_DEMO_LED_BLINK_EN` defined:
  - The blink engine, `blink_mask` and address 3 are implemented as described above.
- Not defined:
  - No prescaler, `phase` or mask registers are synthesised.
  - Writes to address 3 are ignored and address 3 reads 0.
  - `out_port <= data_reg`, still registered with 1-cycle latency.

## Structure
- Package `hello_world_demo_led_pkg` holds:
  - address constants `ADDR_DATA`=0, `ADDR_OUTSET`=1, `ADDR_OUTCLEAR`=2, `ADDR_BLINK`=3
  - the default `BLINK_DIV` constant
- One sub-module, `hello_world_demo_led_blink_timer`:
  - parameter BLINK_DIV
  - inputs `clk`, `reset`, `restart`
  - output `phase`
  - compiled in only under the macro
- The top level contains the decode, `data_reg`, `blink_mask`, the output register and the readdata register.

## Test plan
Bench settings: WIDTH=8, BLINK_DIV=4.
- Reset, then idle: `out_port`=0x00 and `readdata`=0 at every address.
- Write DATA=0x1A5: after 2 edges `out_port`=0xA5, and reading address 0 returns 0x000000A5.
- From DATA=0xA5, write OUTSET=0x0F, then OUTCLEAR=0x81: `out_port` goes to 0xAF and then to 0x2E, and reading address 1 returns 0x2E.
- With the blink macro defined, DATA=0x00 and BLINK=0x03 written at edge k: `out_port`=0x03 after edge k+5 and 0x00 after edge k+9. The toggle repeats every 4 cycles, and address 3 reads 0x03.
- Rewrite BLINK=0x03 exactly on terminal count: `phase` is held at 0 and the next toggle comes 4 edges later.
- Assert `reset` while `out_port`=0x03 mid-blink: `out_port`=0x00 immediately, and after release the first toggle comes 4 edges later.
- Without the blink macro, write BLINK=0xFF: `out_port` is unchanged and address 3 reads 0.
